// File: rtl/pdm_pkg.sv
// Shared types and helpers for the PDM frame packer: word/tag widths, frame type,
// sender state encoding and the byte/checksum formatting functions.
package pdm_pkg;
  localparam int PDM_WORD_W = 5;
  localparam int PDM_TAG_W  = 3;
  localparam int PDM_NUM_CH = 4;

  typedef logic [PDM_NUM_CH-1:0][PDM_WORD_W-1:0] pdm_frame_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } sender_state_t;

  function automatic logic [7:0] pdm_byte(input logic [PDM_TAG_W-1:0] tag,
                                          input logic [PDM_WORD_W-1:0] data);
    return {tag, data};
  endfunction

  function automatic logic [7:0] pdm_frame_csum(input pdm_frame_t frame);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < PDM_NUM_CH; i++) begin
      acc = acc ^ pdm_byte(PDM_TAG_W'(i), frame[i]);
    end
    return acc;
  endfunction
endpackage

// File: rtl/pdm_frame_fifo.sv
// Small synchronous frame FIFO with combinational read of the head entry, so a pop
// can consume the head in the same cycle it is observed non-empty.
module pdm_frame_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             wr_en;
  logic             rd_en;

  // A push while full is refused even if a pop happens in the same cycle.
  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/pdm_frame_packer.sv
// Packs per-channel 5-bit accumulator words into tagged byte frames and streams them
// over valid/ready. Define PDM_FRAME_CSUM_EN to append an XOR checksum byte per frame.
module pdm_frame_packer
  import pdm_pkg::*;
#(
  parameter int NUM_CH     = PDM_NUM_CH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [PDM_WORD_W*NUM_CH-1:0] ch_data,
  output logic [7:0]                   tx_byte,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [7:0]                   frame_drop_cnt,
  output logic [7:0]                   overrun_cnt
);
  localparam int IDX_W = $clog2(NUM_CH);

  pdm_frame_t       word_reg;
  logic [NUM_CH-1:0] have_reg;
  logic [NUM_CH-1:0] overrun_hits;
  logic [8:0]        overrun_sum;
  logic              complete;

  pdm_frame_t       fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  sender_state_t     state_reg;
  pdm_frame_t       shift_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W-1:0]  idx_dec;

  assign complete = &have_reg;

  // A strobe on the completion cycle belongs to the next frame, so it is not an overrun.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ovr
    assign overrun_hits[gi] = ch_valid[gi] && have_reg[gi] && !complete;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
      have_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) begin
          word_reg[i] <= ch_data[i*PDM_WORD_W +: PDM_WORD_W];
          have_reg[i] <= 1'b1;
        end else if (complete) begin
          have_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    overrun_sum = {1'b0, overrun_cnt};
    for (int i = 0; i < NUM_CH; i++) begin
      overrun_sum = overrun_sum + 9'(overrun_hits[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt    <= '0;
      frame_drop_cnt <= '0;
    end else begin
      overrun_cnt <= overrun_sum[8] ? 8'hFF : overrun_sum[7:0];
      if (complete && fifo_full && frame_drop_cnt != 8'hFF) begin
        frame_drop_cnt <= frame_drop_cnt + 8'd1;
      end
    end
  end

  pdm_frame_fifo #(
    .WIDTH ($bits(pdm_frame_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (complete),
    .wr_data (word_reg),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fifo_pop = (state_reg == IDLE) && !fifo_empty;
  assign idx_dec  = idx_reg - IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      tx_byte   <= '0;
      tx_valid  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            shift_reg <= fifo_rd;
            idx_reg   <= IDX_W'(NUM_CH-1);
            tx_byte   <= pdm_byte(PDM_TAG_W'(NUM_CH-1), fifo_rd[NUM_CH-1]);
            tx_valid  <= 1'b1;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx_reg == '0) begin
`ifdef PDM_FRAME_CSUM_EN
              tx_byte   <= pdm_frame_csum(shift_reg);
              state_reg <= CSUM;
`else
              tx_valid  <= 1'b0;
              state_reg <= IDLE;
`endif
            end else begin
              idx_reg <= idx_dec;
              tx_byte <= pdm_byte(PDM_TAG_W'(idx_dec), shift_reg[idx_dec]);
            end
          end
        end
`ifdef PDM_FRAME_CSUM_EN
        CSUM: begin
          if (tx_ready) begin
            tx_valid  <= 1'b0;
            state_reg <= IDLE;
          end
        end
`endif
        default: begin
          tx_valid  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule
